// File: rtl/prog_loader_pkg.sv
// Shared types and widths for the boot-time program loader.
// The optional CSUM state exists only when PROG_LOADER_CHECKSUM_EN is defined.
package prog_loader_pkg;

    localparam int BYTE_W    = 8;
    localparam int WORD_W    = 32;
    localparam int HDR_BYTES = 2;

    typedef enum logic [2:0] {
        ST_IDLE   = 3'd0,
        ST_LEN_HI = 3'd1,
        ST_LEN_LO = 3'd2,
        ST_DATA   = 3'd3,
`ifdef PROG_LOADER_CHECKSUM_EN
        ST_CSUM   = 3'd4,
`endif
        ST_DONE   = 3'd5,
        ST_ERR    = 3'd6
    } state_t;

endpackage

// File: rtl/prog_loader_byte_packer.sv
// Packs big-endian bytes into 32-bit words; word_done marks the 4th byte of each word.
// The completed word is presented combinationally so the caller can capture it on that same edge.
module byte_packer
    import prog_loader_pkg::*;
(
    input  logic              clk,
    input  logic              reset,
    input  logic              byte_en,
    input  logic [BYTE_W-1:0] byte_in,
    output logic [WORD_W-1:0] word,
    output logic              word_done
);

    logic [1:0]               cnt_q;
    logic [WORD_W-BYTE_W-1:0] asm_q;

    always_ff @(posedge clk or negedge reset) begin
        if (!reset) begin
            cnt_q <= '0;
            asm_q <= '0;
        end else if (byte_en) begin
            cnt_q <= cnt_q + 2'd1;
            asm_q <= {asm_q[WORD_W-2*BYTE_W-1:0], byte_in};
        end
    end

    assign word      = {asm_q, byte_in};
    assign word_done = byte_en && (cnt_q == 2'd3);

endmodule

// File: rtl/prog_loader.sv
// Streams a length-prefixed program into instruction memory and holds the core in reset until done.
// Define PROG_LOADER_CHECKSUM_EN to require a trailing XOR checksum byte.
//
// state   | meaning
// IDLE    | one cycle after reset release
// LEN_HI  | waiting for word count MSB
// LEN_LO  | waiting for word count LSB, range check
// DATA    | receiving instruction bytes
// CSUM    | waiting for checksum byte (checksum builds only)
// DONE    | program loaded, core released
// ERR     | load aborted, core held
module prog_loader
    import prog_loader_pkg::*;
#(
    parameter logic [31:0] BASE_ADDR = 32'h0000_0000,
    parameter int          MAX_WORDS = 256
) (
    input  logic              clk,
    input  logic              reset,
    input  logic              rx_valid,
    input  logic [BYTE_W-1:0] rx_data,
    output logic              rx_ready,
    output logic              imem_we,
    output logic [31:0]       imem_addr,
    output logic [WORD_W-1:0] imem_wdata,
    output logic              cpu_reset,
    output logic              load_done,
    output logic              load_err
);

    localparam logic [16:0] MAX_LEN = 17'(MAX_WORDS);
`ifdef PROG_LOADER_CHECKSUM_EN
    localparam state_t ST_FINAL = ST_CSUM;
`else
    localparam state_t ST_FINAL = ST_DONE;
`endif

    state_t                      state_q, state_d;
    logic [HDR_BYTES*BYTE_W-1:0] len_q;
    logic [15:0]                 len_rx;
    logic [15:0]                 idx_q;
    logic                        accept, byte_en, word_done;
    logic [WORD_W-1:0]           word;

    assign accept  = rx_valid && rx_ready;
    assign byte_en = accept && (state_q == ST_DATA);
    assign len_rx  = {len_q[15:8], rx_data};

    byte_packer u_packer (
        .clk       (clk),
        .reset     (reset),
        .byte_en   (byte_en),
        .byte_in   (rx_data),
        .word      (word),
        .word_done (word_done)
    );

`ifdef PROG_LOADER_CHECKSUM_EN
    logic [BYTE_W-1:0] csum_q;

    always_ff @(posedge clk or negedge reset) begin
        if (!reset)
            csum_q <= '0;
        else if (byte_en)
            csum_q <= csum_q ^ rx_data;
    end
`endif

    always_comb begin
        state_d   = state_q;
        rx_ready  = 1'b0;
        cpu_reset = 1'b1;
        load_done = 1'b0;
        load_err  = 1'b0;
        case (state_q)
            ST_IDLE:   state_d = ST_LEN_HI;
            ST_LEN_HI: begin
                rx_ready = 1'b1;
                if (rx_valid) state_d = ST_LEN_LO;
            end
            ST_LEN_LO: begin
                rx_ready = 1'b1;
                if (rx_valid) begin
                    if ({1'b0, len_rx} > MAX_LEN) state_d = ST_ERR;
                    else if (len_rx == 16'd0)     state_d = ST_FINAL;
                    else                          state_d = ST_DATA;
                end
            end
            ST_DATA: begin
                rx_ready = 1'b1;
                if (word_done && (idx_q == len_q - 16'd1)) state_d = ST_FINAL;
            end
`ifdef PROG_LOADER_CHECKSUM_EN
            ST_CSUM: begin
                rx_ready = 1'b1;
                if (rx_valid) state_d = (rx_data == csum_q) ? ST_DONE : ST_ERR;
            end
`endif
            ST_DONE: begin
                cpu_reset = 1'b0;
                load_done = 1'b1;
            end
            ST_ERR:  load_err = 1'b1;
            default: state_d  = ST_IDLE;
        endcase
    end

    // The write register is loaded on the 4th-byte edge, so a byte arriving during the strobe cannot disturb it.
    always_ff @(posedge clk or negedge reset) begin
        if (!reset) begin
            state_q    <= ST_IDLE;
            len_q      <= '0;
            idx_q      <= '0;
            imem_we    <= 1'b0;
            imem_addr  <= '0;
            imem_wdata <= '0;
        end else begin
            state_q <= state_d;
            imem_we <= word_done;
            if (accept && (state_q == ST_LEN_HI)) len_q <= {rx_data, 8'h00};
            if (accept && (state_q == ST_LEN_LO)) len_q <= len_rx;
            if (word_done) begin
                imem_wdata <= word;
                imem_addr  <= BASE_ADDR + {14'd0, idx_q, 2'b00};
                idx_q      <= idx_q + 16'd1;
            end
        end
    end

endmodule
